idss_feeder: RTL
================

// Module: idss_feeder
// PURPOSE
//  Producer side of the IDSS row interface. It fetches feature-map pixels from external
//  memory and drives row_1/row_2/row_3, LE_select and shift into the IDSS, one output row
//  strip (centre row y) at a time.
//  Each strip column is handled in order: all NB_CSS channels are loaded, then one shift
//  pulse is issued. win_valid flags a complete 3x3xNB_CSS window to the downstream PE array.
// PARAMETERS
//  IO_DATA_WIDTH      16    pixel width
//  NB_CSS             4     channels per IDSS (fixed 4 while LE_select is 2 bits)
//  FEATURE_MAP_WIDTH  1024  W, columns
//  FEATURE_MAP_HEIGHT 1024  H, rows
//  ADDR_WIDTH         20    external memory word address width
// PORTS
//  clk         in   1               clock
//  rst_in      in   1               synchronous reset, active-high
//  start       in   1               begin strip; sampled only in IDLE
//  row_y       in   clog2(H)        centre row of strip, sampled with start
//  busy        out  1               high from start accept until DONE exits
//  mem_req     out  1               read request
//  mem_addr    out  ADDR_WIDTH      word address = (ch*H + r)*W + c
//  mem_gnt     in   1               request accepted this cycle
//  mem_rvalid  in   1               read data valid, exactly 1 cycle after gnt
//  mem_rdata   in   IO_DATA_WIDTH   read data
//  row_1/2/3   out  IO_DATA_WIDTH   pixels of rows y-1 / y / y+1 to IDSS
//  LE_select   out  2               CSS being loaded
//  shift       out  1               single-cycle column shift pulse
//  win_valid   out  1               3x3 window in IDSS complete
//  win_ready   in   1               downstream consumed window; gates shift
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0: busy, mem_req, mem_addr, row_*, LE_select, shift,
//    win_valid. Reset mid-strip aborts immediately with no further mem_req.
//  - FSM states: IDLE -> FETCH(r=0..2) -> LOAD -> (next ch ? FETCH : SHIFT) -> ... -> DONE -> IDLE.
//  - FETCH: holds mem_req and mem_addr stable until mem_gnt. Captures mem_rdata on
//    mem_rvalid into holding reg r, then advances r.
//  - LOAD (1 cycle): row_1..3 <= holding regs; LE_select <= ch.
//  - The IDSS always loads the CSS selected by LE_select. So row_* and LE_select hold
//    their last values whenever the feeder is not in LOAD; reloading the same data is
//    harmless.
//  - SHIFT: shift=1 for exactly one cycle after channel NB_CSS-1 is loaded.
//  - Window fill: once 3 columns are shifted in, win_valid=1 from the cycle after each
//    shift. It holds until win_ready is seen high; the next shift is blocked while
//    win_valid && !win_ready.
//  - Per column: 3*NB_CSS reads (min 2 cycles each) + NB_CSS LOAD + 1 SHIFT.
//    Minimum is 29 cycles per column for NB_CSS=4.
//  - Column counter c walks the strip range (see CONFIGURATION).
//  - DONE: 1 cycle, busy drops at exit. start is ignored while busy.
//  - start and rst_in in the same cycle: reset wins.
//  - mem_addr is computed on a 32-bit intermediate and truncated to ADDR_WIDTH.
// CONFIGURATION
//  - IDSS_FEEDER_ZERO_PAD_EN defined: the strip spans c = -1..W, giving W output windows.
//    Any pixel with r or c outside the map is 0 and is not requested from memory: no
//    mem_req, the holding reg is written 0 in 1 cycle. row_y = 0 and row_y = H-1 are legal.
//  - Undefined: the strip spans c = 0..W-1, giving W-2 windows. row_y must be in 1..H-2;
//    start with row_y outside that range is ignored, busy stays 0.
// STRUCTURE
//  - Package idss_pkg: typedef pixel_t (logic [IO_DATA_WIDTH-1:0]), feeder_state_e enum,
//    localparam NB_CSS = 4. Also the address helper function
//    pix_addr(ch, r, c, W, H), shared with the output writer.
//  - One sub-module, idss_feeder_addr_gen: ch/r/c counters, padding detect, mem_addr.
//    The FSM and the output registers stay in idss_feeder.
// TESTING (W=H=8, NB_CSS=4, memory model word = addr[15:0], win_ready tied 1 unless noted)
//  1 Reset: rst_in held 3 cycles with start=1 -> all outputs 0, no mem_req, busy=0.
//  2 Unpadded strip, row_y=3 -> 6 win_valid pulses and 8 shift pulses. First LOAD of ch0
//    shows row_1=16, row_2=24, row_3=32 with LE_select=0.
//  3 ZERO_PAD_EN, row_y=0 -> row_1=0 for every load with no reads at r=-1;
//    8 win_valid pulses; first column all-zero rows.
//  4 mem_gnt withheld 5 cycles on the 2nd read -> mem_req/mem_addr stable throughout,
//    data order intact.
//  5 win_ready=0 for 10 cycles at the first window -> no shift pulse, win_valid stays 1,
//    row_*/LE_select frozen.
//  6 rst_in asserted mid-FETCH of column 4 -> next cycle IDLE with outputs 0.
//    A fresh start then replays from column 0.

Source files
------------

// File: rtl/idss_pkg.sv
// Shared types and helpers for the IDSS row interface.
//   pixel_t         default-width feature-map pixel
//   feeder_state_e  feeder FSM states
//   NB_CSS          channels per IDSS (LE_select is 2 bits wide)
//   pix_addr()      word address of pixel (ch, r, c) in a W x H x ch map,
//                   also used by the output writer
package idss_pkg;

    localparam int NB_CSS  = 4;
    localparam int PIXEL_W = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,   // request pixel (or zero-fill a padded one)
        ST_WAIT,    // wait for read data of the granted request
        ST_LOAD,    // drive holding regs onto row_1..3 for current CSS
        ST_SHIFT,   // one-cycle column shift pulse
        ST_DONE
    } feeder_state_e;

    function automatic logic [31:0] pix_addr(input int ch, input int r, input int c,
                                             input int w, input int h);
        int a;
        a = (ch * h + r) * w + c;
        return 32'(a);
    endfunction

endpackage

// File: rtl/idss_feeder_addr_gen.sv
// Channel / row / column walker for one strip plus padding detect and address.
//   clk, rst_in        clock, synchronous active-high reset
//   init, row_y        latch centre row and rewind to the first strip column
//   adv_r/adv_ch/adv_c step row index / channel / column (column wins)
//   ch, ridx           current channel and row index (0..2 => y-1..y+1)
//   last_r/ch/c        current counter is at its final value
//   pad                current pixel lies outside the map (always 0 unpadded)
//   addr               word address of the current pixel
// Macro IDSS_FEEDER_ZERO_PAD_EN widens the strip to c = -1..W.
module idss_feeder_addr_gen
    import idss_pkg::*;
#(
    parameter int W          = 1024,
    parameter int H          = 1024,
    parameter int ADDR_WIDTH = 20,
    parameter int RY_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  init,
    input  logic [RY_W-1:0]       row_y,
    input  logic                  adv_r,
    input  logic                  adv_ch,
    input  logic                  adv_c,
    output logic [1:0]            ch,
    output logic [1:0]            ridx,
    output logic                  last_r,
    output logic                  last_ch,
    output logic                  last_c,
    output logic                  pad,
    output logic [ADDR_WIDTH-1:0] addr
);

`ifdef IDSS_FEEDER_ZERO_PAD_EN
    localparam int C_FIRST = -1;
    localparam int C_LAST  = W;
`else
    localparam int C_FIRST = 0;
    localparam int C_LAST  = W - 1;
`endif

    logic [RY_W-1:0]    y_q;
    logic signed [31:0] c_q;
    logic signed [31:0] r_abs;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            y_q  <= '0;
            ch   <= '0;
            ridx <= '0;
            c_q  <= C_FIRST;
        end else if (init) begin
            y_q  <= row_y;
            ch   <= '0;
            ridx <= '0;
            c_q  <= C_FIRST;
        end else if (adv_c) begin
            ch   <= '0;
            ridx <= '0;
            c_q  <= c_q + 32'sd1;
        end else if (adv_ch) begin
            ch   <= ch + 2'd1;
            ridx <= '0;
        end else if (adv_r) begin
            ridx <= ridx + 2'd1;
        end
    end

    assign r_abs   = $signed(32'(y_q)) + $signed(32'(ridx)) - 32'sd1;
    assign last_r  = (ridx == 2'd2);
    assign last_ch = (ch == 2'(NB_CSS - 1));
    assign last_c  = (c_q == C_LAST);

`ifdef IDSS_FEEDER_ZERO_PAD_EN
    assign pad = (r_abs < 0) || (r_abs >= H) || (c_q < 0) || (c_q >= W);
`else
    assign pad = 1'b0;
`endif

    // Out-of-map pixels never reach the memory, so their (meaningless)
    // address is only ever seen internally.
    assign addr = ADDR_WIDTH'(pix_addr(int'(ch), int'(r_abs), int'(c_q), W, H));

endmodule

// File: rtl/idss_feeder.sv
// Producer side of the IDSS row interface: fetches a 3-row strip centred on
// row_y, channel by channel, and drives row_1..3 / LE_select / shift.
//   clk, rst_in            clock, synchronous active-high reset
//   start, row_y, busy     strip handshake (start only sampled in IDLE)
//   mem_req/addr/gnt       read request channel, held until granted
//   mem_rvalid/rdata       read data, one cycle after grant
//   row_1..3, LE_select    pixel rows y-1/y/y+1 and CSS being loaded
//   shift                  one-cycle column shift pulse
//   win_valid, win_ready   complete 3x3xNB_CSS window handshake
// Macro IDSS_FEEDER_ZERO_PAD_EN enables zero padding (W windows per strip,
// any row_y accepted); without it the strip gives W-2 windows and row_y
// must be in 1..H-2.
module idss_feeder
    import idss_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int ADDR_WIDTH         = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_in,
    input  logic                                  start,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] row_y,
    output logic                                  busy,
    output logic                                  mem_req,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic                                  mem_gnt,
    input  logic                                  mem_rvalid,
    input  logic [IO_DATA_WIDTH-1:0]              mem_rdata,
    output logic [IO_DATA_WIDTH-1:0]              row_1,
    output logic [IO_DATA_WIDTH-1:0]              row_2,
    output logic [IO_DATA_WIDTH-1:0]              row_3,
    output logic [1:0]                            LE_select,
    output logic                                  shift,
    output logic                                  win_valid,
    input  logic                                  win_ready
);

    localparam int RY_W = $clog2(FEATURE_MAP_HEIGHT);

    feeder_state_e state, state_nx;

    logic [2:0][IO_DATA_WIDTH-1:0] hold_q;
    logic [1:0]                    ncol_q;    // saturating count of shifted columns
    logic [1:0]                    ch, ridx;
    logic                          last_r, last_ch, last_c, pad;
    logic [ADDR_WIDTH-1:0]         gen_addr;
    logic                          init, adv_r, adv_ch, adv_c;
    logic                          cap, do_load, do_shift;
    logic                          row_ok, win_block;
    logic [IO_DATA_WIDTH-1:0]      cap_data;

    idss_feeder_addr_gen #(
        .W          (FEATURE_MAP_WIDTH),
        .H          (FEATURE_MAP_HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RY_W       (RY_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_in  (rst_in),
        .init    (init),
        .row_y   (row_y),
        .adv_r   (adv_r),
        .adv_ch  (adv_ch),
        .adv_c   (adv_c),
        .ch      (ch),
        .ridx    (ridx),
        .last_r  (last_r),
        .last_ch (last_ch),
        .last_c  (last_c),
        .pad     (pad),
        .addr    (gen_addr)
    );

`ifdef IDSS_FEEDER_ZERO_PAD_EN
    assign row_ok = (int'(row_y) < FEATURE_MAP_HEIGHT);
`else
    assign row_ok = (row_y != '0) && (int'(row_y) < FEATURE_MAP_HEIGHT - 1);
`endif

    // The IDSS keeps loading whatever LE_select points at, so neither a new
    // load nor a shift may happen while the current window is unconsumed.
    assign win_block = win_valid && !win_ready;

    always_comb begin
        state_nx = state;
        init     = 1'b0;
        adv_r    = 1'b0;
        adv_ch   = 1'b0;
        adv_c    = 1'b0;
        cap      = 1'b0;
        do_load  = 1'b0;
        do_shift = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && row_ok) begin
                    init     = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pad) begin
                    cap = 1'b1;
                    if (last_r) state_nx = ST_LOAD;
                    else        adv_r    = 1'b1;
                end else if (mem_gnt) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    cap = 1'b1;
                    if (last_r) state_nx = ST_LOAD;
                    else begin
                        adv_r    = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_LOAD: begin
                if (!win_block) begin
                    do_load = 1'b1;
                    if (last_ch) state_nx = ST_SHIFT;
                    else begin
                        adv_ch   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_SHIFT: begin
                if (!win_block) begin
                    do_shift = 1'b1;
                    if (last_c) state_nx = ST_DONE;
                    else begin
                        adv_c    = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign mem_req  = (state == ST_FETCH) && !pad;
    assign mem_addr = mem_req ? gen_addr : '0;
    assign shift    = do_shift;
    // Captures in FETCH are only ever padded pixels.
    assign cap_data = (state == ST_FETCH) ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            hold_q    <= '0;
            row_1     <= '0;
            row_2     <= '0;
            row_3     <= '0;
            LE_select <= '0;
            win_valid <= 1'b0;
            ncol_q    <= '0;
        end else begin
            state <= state_nx;
            if (cap) hold_q[ridx] <= cap_data;
            if (do_load) begin
                row_1     <= hold_q[0];
                row_2     <= hold_q[1];
                row_3     <= hold_q[2];
                LE_select <= ch;
            end
            if (init) ncol_q <= '0;
            else if (do_shift && ncol_q != 2'd3) ncol_q <= ncol_q + 2'd1;
            // A window exists once this shift brings in the third column.
            if (do_shift && ncol_q >= 2'd2) win_valid <= 1'b1;
            else if (win_valid && win_ready) win_valid <= 1'b0;
        end
    end

endmodule
